// File: rtl/rot_pkg.sv
// Shared types and helpers for the rotation result collector.
// Provides the float word width, the packed quaternion entry type,
// the word-select constants (positions in w,x,y,z order) and a word
// selection helper used by the output serialiser.
package rot_pkg;

  localparam int FLOAT_W = 32;

  typedef struct packed {
    logic [FLOAT_W-1:0] w;
    logic [FLOAT_W-1:0] x;
    logic [FLOAT_W-1:0] y;
    logic [FLOAT_W-1:0] z;
  } quat_t;

  localparam logic [1:0] IDX_W = 2'd0;
  localparam logic [1:0] IDX_X = 2'd1;
  localparam logic [1:0] IDX_Y = 2'd2;
  localparam logic [1:0] IDX_Z = 2'd3;

  // Pick one component of an entry by its position in w,x,y,z order.
  function automatic logic [FLOAT_W-1:0] quat_word(input quat_t q, input logic [1:0] sel);
    case (sel)
      IDX_W:   return q.w;
      IDX_X:   return q.x;
      IDX_Y:   return q.y;
      IDX_Z:   return q.z;
      default: return q.x;
    endcase
  endfunction

endpackage

// File: rtl/rot_entry_fifo.sv
// Synchronous FIFO of quaternion entries.
// Ports:
//   clk, resetn   : clock, synchronous active-low reset
//   i_push/i_data : push request and entry
//   i_pop         : pop the head (ignored when empty)
//   o_accept      : push actually taken (not full, or a pop frees a slot)
//   o_head_nxt    : entry that will be at the head after this cycle
//   o_empty_nxt   : FIFO will be empty after this cycle
//   o_level       : entries currently held
module rot_entry_fifo
  import rot_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_push,
  input  quat_t                    i_data,
  input  logic                     i_pop,
  output logic                     o_accept,
  output quat_t                    o_head_nxt,
  output logic                     o_empty_nxt,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  quat_t           r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;

  logic            w_full;
  logic            w_empty;
  logic            w_pop_ok;
  logic [PW-1:0]   w_level;
  logic [PW-1:0]   w_remain;
  logic [PW-1:0]   w_level_nxt;
  logic [PW-1:0]   w_rd_ptr_nxt;

  // Wrap bit distinguishes full from empty when the low bits match.
  assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_pop_ok     = i_pop & ~w_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign o_accept     = i_push & (~w_full | w_pop_ok);
  assign w_level      = r_wr_ptr - r_rd_ptr;
  assign w_remain     = w_level - PW'(w_pop_ok);
  assign w_level_nxt  = w_remain + PW'(o_accept);
  assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop_ok);
  assign o_empty_nxt  = (w_level_nxt == '0);
  assign o_level      = w_level;
  // If nothing older survives this cycle, the incoming entry becomes head.
  assign o_head_nxt   = (w_remain == '0) ? i_data : r_mem[w_rd_ptr_nxt[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(o_accept);
      r_rd_ptr <= w_rd_ptr_nxt;
    end
  end

  // Entry storage write
  always_ff @(posedge clk) begin
    if (o_accept) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/rotation_result_collector.sv
// Collects rotated quaternions from the non-stallable rotation stage,
// buffers them and serialises each entry as 32-bit float words.
// Ports:
//   clk, resetn          : clock, synchronous active-low reset
//   in_w/x/y/z, in_valid : rotation result and its one-cycle strobe
//   m_data/m_valid/m_ready/m_last/m_index : output word stream
//   fifo_level           : entries held, including a partially sent head
//   overflow, drop_count : sticky drop flag and saturating drop counter
//   clear_overflow       : clears overflow and drop_count
module rotation_result_collector
  import rot_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int KEEP_W = 0,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [FLOAT_W-1:0]     in_w,
  input  logic [FLOAT_W-1:0]     in_x,
  input  logic [FLOAT_W-1:0]     in_y,
  input  logic [FLOAT_W-1:0]     in_z,
  input  logic                   in_valid,
  output logic [FLOAT_W-1:0]     m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic [1:0]             m_index,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_count,
  input  logic                   clear_overflow
);

  localparam int         NW       = 3 + KEEP_W;
  localparam logic [1:0] LAST_IDX = 2'(NW - 1);
  // Without w the stream index 0 maps to x.
  localparam logic [1:0] SEL_OFS  = (KEEP_W != 0) ? 2'd0 : 2'd1;

  logic [FLOAT_W-1:0] r_m_data;
  logic               r_m_valid;
  logic               r_m_last;
  logic [1:0]         r_m_index;
  logic               r_overflow;
  logic [CNT_W-1:0]   r_drop_count;

  quat_t              w_in_quat;
  quat_t              w_head_nxt;
  logic               w_empty_nxt;
  logic               w_accept;
  logic               w_xfer;
  logic               w_pop;
  logic               w_drop;
  logic [1:0]         w_idx_nxt;

  assign w_in_quat = '{w: in_w, x: in_x, y: in_y, z: in_z};
  assign w_xfer    = r_m_valid & m_ready;
  assign w_pop     = w_xfer & r_m_last;
  assign w_drop    = in_valid & ~w_accept;

  rot_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .i_push      (in_valid),
    .i_data      (w_in_quat),
    .i_pop       (w_pop),
    .o_accept    (w_accept),
    .o_head_nxt  (w_head_nxt),
    .o_empty_nxt (w_empty_nxt),
    .o_level     (fifo_level)
  );

  // Next word index within the head entry
  always_comb begin
    w_idx_nxt = r_m_index;
    if (w_pop) begin
      w_idx_nxt = 2'd0;
    end else if (w_xfer) begin
      w_idx_nxt = r_m_index + 2'd1;
    end else begin
      w_idx_nxt = r_m_index;
    end
  end

  // Registered stream outputs, computed from the post-cycle FIFO head
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
      r_m_index <= 2'd0;
    end else begin
      r_m_valid <= ~w_empty_nxt;
      r_m_data  <= w_empty_nxt ? '0 : quat_word(w_head_nxt, w_idx_nxt + SEL_OFS);
      r_m_last  <= ~w_empty_nxt & (w_idx_nxt == LAST_IDX);
      r_m_index <= w_empty_nxt ? 2'd0 : w_idx_nxt;
    end
  end

  // Overflow flag and saturating drop counter; a drop beats a clear
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow   <= 1'b1;
      if (clear_overflow) begin
        r_drop_count <= CNT_W'(1);
      end else if (r_drop_count != '1) begin
        r_drop_count <= r_drop_count + CNT_W'(1);
      end else begin
        r_drop_count <= r_drop_count;
      end
    end else if (clear_overflow) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_overflow   <= r_overflow;
      r_drop_count <= r_drop_count;
    end
  end

  assign m_data     = r_m_data;
  assign m_valid    = r_m_valid;
  assign m_last     = r_m_last;
  assign m_index    = r_m_index;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_rotation_result_collector.sv
// Scoreboard bench: expected words are queued when an entry is driven and
// compared as the collector hands words over.
module tb_rotation_result_collector;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] in_w = 32'h0, in_x = 32'h0, in_y = 32'h0, in_z = 32'h0;
  logic        in_valid = 1'b0;
  logic [31:0] m_data;
  logic        m_valid, m_last;
  logic        m_ready = 1'b0;
  logic [1:0]  m_index;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic [15:0] drop_count;
  logic        clear_overflow = 1'b0;

  logic [31:0] k_in_w = 32'h0, k_in_x = 32'h0, k_in_y = 32'h0, k_in_z = 32'h0;
  logic        k_in_valid = 1'b0;
  logic [31:0] k_data;
  logic        k_valid, k_last;
  logic        k_ready = 1'b0;
  logic [1:0]  k_index;
  logic [2:0]  k_level;
  logic        k_overflow;
  logic [15:0] k_drop_count;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  idx;
    logic        last;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  rotation_result_collector #(.DEPTH(8), .KEEP_W(0), .CNT_W(16)) u_dut (
    .clk(clk), .resetn(resetn),
    .in_w(in_w), .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_valid(in_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .m_index(m_index), .fifo_level(fifo_level), .overflow(overflow),
    .drop_count(drop_count), .clear_overflow(clear_overflow)
  );

  rotation_result_collector #(.DEPTH(4), .KEEP_W(1), .CNT_W(16)) u_dut_w (
    .clk(clk), .resetn(resetn),
    .in_w(k_in_w), .in_x(k_in_x), .in_y(k_in_y), .in_z(k_in_z), .in_valid(k_in_valid),
    .m_data(k_data), .m_valid(k_valid), .m_ready(k_ready), .m_last(k_last),
    .m_index(k_index), .fifo_level(k_level), .overflow(k_overflow),
    .drop_count(k_drop_count), .clear_overflow(1'b0)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one result strobe; queue its words when it should be accepted.
  task automatic push_entry(input logic [31:0] w, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] z, input bit accept);
    in_w = w; in_x = x; in_y = y; in_z = z;
    in_valid = 1'b1;
    if (accept) begin
      sb_q.push_back('{data: x, idx: 2'd0, last: 1'b0});
      sb_q.push_back('{data: y, idx: 2'd1, last: 1'b0});
      sb_q.push_back('{data: z, idx: 2'd2, last: 1'b1});
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_val("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  // Scoreboard monitor: every handshake on the main instance pops one word.
  always @(negedge clk) begin
    if (resetn && m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        check_val("sb_extra_word", {62'd0, m_valid, m_ready}, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("mon_data", 64'(m_data), 64'(e.data));
        check_val("mon_index", 64'(m_index), 64'(e.idx));
        check_val("mon_last", 64'(m_last), 64'(e.last));
      end
    end
  end

  initial begin
    logic [31:0] kexp [4];
    kexp[0] = 32'h3F80_0000; kexp[1] = 32'h0000_0000;
    kexp[2] = 32'h0000_0000; kexp[3] = 32'hBF80_0000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_valid", 64'(m_valid), 64'd0);
    check_val("rst_data", 64'(m_data), 64'd0);
    check_val("rst_last", 64'(m_last), 64'd0);
    check_val("rst_index", 64'(m_index), 64'd0);
    check_val("rst_level", 64'(fifo_level), 64'd0);
    check_val("rst_overflow", 64'(overflow), 64'd0);
    check_val("rst_drops", 64'(drop_count), 64'd0);
    resetn = 1'b1;
    tick();

    // Single entry, consumer always ready
    m_ready = 1'b1;
    push_entry(32'h0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b1);
    check_val("single_valid", 64'(m_valid), 64'd1);
    check_val("single_level", 64'(fifo_level), 64'd1);
    check_val("single_first", 64'(m_data), 64'h3F80_0000);
    wait_drain();
    check_val("single_level_end", 64'(fifo_level), 64'd0);
    check_val("single_valid_end", 64'(m_valid), 64'd0);

    // Backpressure holds the head word stable
    m_ready = 1'b0;
    push_entry(32'h0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("bp_valid", 64'(m_valid), 64'd1);
      check_val("bp_data", 64'(m_data), 64'h3F80_0000);
      check_val("bp_index", 64'(m_index), 64'd0);
    end
    tick();
    m_ready = 1'b1;
    wait_drain();
    check_val("bp_level_end", 64'(fifo_level), 64'd0);

    // Overflow: ten strobes into eight slots
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push_entry(32'(i), 32'(i + 16), 32'(i + 32), 32'(i + 48), i < 8);
    end
    check_val("ovf_level", 64'(fifo_level), 64'd8);
    check_val("ovf_flag", 64'(overflow), 64'd1);
    check_val("ovf_drops", 64'(drop_count), 64'd2);
    m_ready = 1'b1;
    wait_drain();
    check_val("ovf_level_end", 64'(fifo_level), 64'd0);
    check_val("ovf_flag_sticky", 64'(overflow), 64'd1);

    // Reset in the middle of an entry, after words 0 and 1
    m_ready = 1'b0;
    push_entry(32'h0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1'b1);
    m_ready = 1'b1;
    tick();
    tick();
    check_val("mid_index", 64'(m_index), 64'd2);
    m_ready = 1'b0;
    resetn = 1'b0;
    sb_q.delete();
    tick();
    resetn = 1'b1;
    @(negedge clk);
    check_val("mid_rst_valid", 64'(m_valid), 64'd0);
    check_val("mid_rst_level", 64'(fifo_level), 64'd0);
    check_val("mid_rst_overflow", 64'(overflow), 64'd0);
    check_val("mid_rst_index", 64'(m_index), 64'd0);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    push_entry(32'h0, 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003, 1'b1);
    wait_drain();

    // Fill, then drop together with a clear: the drop wins
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_entry(32'h0, 32'(i + 100), 32'(i + 200), 32'(i + 300), 1'b1);
    end
    clear_overflow = 1'b1;
    push_entry(32'h0, 32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 1'b0);
    clear_overflow = 1'b0;
    check_val("clr_drop_flag", 64'(overflow), 64'd1);
    check_val("clr_drop_count", 64'(drop_count), 64'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check_val("clr_flag", 64'(overflow), 64'd0);
    check_val("clr_count", 64'(drop_count), 64'd0);

    // Full FIFO: final-word pop and push in the same cycle
    m_ready = 1'b1;
    tick();
    tick();
    check_val("fullpop_pre_index", 64'(m_index), 64'd2);
    push_entry(32'h0, 32'hBEEF_0000, 32'hBEEF_0001, 32'hBEEF_0002, 1'b1);
    m_ready = 1'b0;
    check_val("fullpop_level", 64'(fifo_level), 64'd8);
    check_val("fullpop_drops", 64'(drop_count), 64'd0);
    check_val("fullpop_flag", 64'(overflow), 64'd0);
    check_val("fullpop_index", 64'(m_index), 64'd0);
    m_ready = 1'b1;
    wait_drain();
    check_val("fullpop_level_end", 64'(fifo_level), 64'd0);
    m_ready = 1'b0;

    // w kept as a fourth word, emitted first
    k_ready = 1'b1;
    k_in_w = 32'h3F80_0000; k_in_x = 32'h0; k_in_y = 32'h0; k_in_z = 32'hBF80_0000;
    k_in_valid = 1'b1;
    tick();
    k_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("kw_valid", 64'(k_valid), 64'd1);
      check_val("kw_data", 64'(k_data), 64'(kexp[i]));
      check_val("kw_index", 64'(k_index), 64'(i));
      check_val("kw_last", 64'(k_last), 64'(i == 3));
    end
    @(negedge clk);
    check_val("kw_valid_end", 64'(k_valid), 64'd0);
    check_val("kw_level_end", 64'(k_level), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
